// File: rtl/amo_mem_arbiter.sv
// amo_mem_arbiter: round-robin arbiter sequencing load/store/LR/SC from N harts onto one memory port and reservation table
module amo_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_IDS = 2,
  localparam int ID_W = (N_IDS > 1) ? $clog2(N_IDS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_IDS-1:0]             i_req,
  input  logic [2*N_IDS-1:0]           i_op,
  input  logic [ADDR_WIDTH*N_IDS-1:0]  i_addr,
  input  logic [DATA_WIDTH*N_IDS-1:0]  i_wdata,
  output logic [N_IDS-1:0]             o_ack,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
  output logic                         o_tbl_wr_en,
  output logic                         o_tbl_set_res,
  output logic                         o_tbl_check_res,
  output logic [ID_W-1:0]              o_tbl_id,
  output logic [ADDR_WIDTH-1:0]        o_tbl_addr,
  input  logic                         i_tbl_gnt
);
  typedef enum logic [1:0] {IDLE, CHECK, MEM, RESP} state_e;
  localparam logic [ID_W:0] NK = (ID_W+1)'(N_IDS);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_IDS - 1);
  state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gid;
  logic [1:0] op_q, op_d, gop;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ID_W:0] k;
  logic found;
  always_comb begin
    found = 1'b0;
    gid = '0;
    k = '0;
    for (int i = 0; i < N_IDS; i++) begin
      k = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      k = (k >= NK) ? k - NK : k;
      if (!found && i_req[k[ID_W-1:0]]) begin
        found = 1'b1;
        gid = k[ID_W-1:0];
      end
    end
  end
  assign gop = i_op[{gid, 1'b0} +: 2];
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        id_d = gid;
        op_d = gop;
        addr_d = i_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = i_wdata[gid*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr_d = (gid == LAST) ? '0 : gid + 1'b1;
        state_d = (gop == 2'b11) ? CHECK : MEM;
      end
      // a lost reservation answers 1 without touching memory
      CHECK: begin
        state_d = i_tbl_gnt ? MEM : RESP;
        rdata_d = i_tbl_gnt ? '0 : DATA_WIDTH'(1);
      end
      MEM: if (i_mem_ack) begin
        state_d = RESP;
        rdata_d = op_q[0] ? '0 : i_mem_rdata;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign o_ack = (state_q == RESP) ? (N_IDS'(1) << id_q) : '0;
  assign o_rdata = (state_q == RESP) ? rdata_q : '0;
  assign o_mem_req = state_q == MEM;
  assign o_mem_we = o_mem_req & op_q[0];
  assign o_mem_addr = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_tbl_wr_en = o_mem_req & i_mem_ack & op_q[0];
  assign o_tbl_set_res = o_mem_req & i_mem_ack & (op_q == 2'b10);
  assign o_tbl_check_res = state_q == CHECK;
  assign o_tbl_id = id_q;
  assign o_tbl_addr = addr_q;
endmodule

// File: tb/tb_amo_mem_arbiter.sv
// tb_amo_mem_arbiter: directed bench with a latency-programmable memory responder
module tb_amo_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_rst;
  logic [1:0] i_req, o_ack;
  logic [3:0] i_op;
  logic [63:0] i_addr, i_wdata;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata, o_tbl_addr;
  logic o_mem_req, o_mem_we, i_mem_ack, o_tbl_wr_en, o_tbl_set_res, o_tbl_check_res, i_tbl_gnt;
  logic [0:0] o_tbl_id;
  int n_chk = 0, n_pass = 0, mem_lat = 1, mcnt = 0;
  logic [31:0] mem_data = '0;

  amo_mem_arbiter dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_op(i_op), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ack(o_ack), .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_tbl_wr_en(o_tbl_wr_en), .o_tbl_set_res(o_tbl_set_res), .o_tbl_check_res(o_tbl_check_res),
    .o_tbl_id(o_tbl_id), .o_tbl_addr(o_tbl_addr), .i_tbl_gnt(i_tbl_gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // advance one clock; ack memory mem_lat cycles after o_mem_req rose
  task automatic cycle();
    @(posedge clk);
    #1;
    i_mem_ack = 1'b0;
    if (o_mem_req) begin
      mcnt++;
      if (mcnt == mem_lat + 1) begin
        i_mem_ack = 1'b1;
        i_mem_rdata = mem_data;
      end
    end else mcnt = 0;
    #1;
  endtask

  task automatic do_op(input string tag, input int h, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] md, input logic gnt,
                       input logic [31:0] exp_rd, input int exp_cyc);
    int got_cyc = -1, set_n = 0, wr_n = 0, chk_n = 0, mem_n = 0, bad = 0;
    logic [1:0] ackv = '0;
    logic [31:0] rd = '0;
    i_req[h] = 1'b1;
    i_op[2*h +: 2] = op;
    i_addr[32*h +: 32] = a;
    i_wdata[32*h +: 32] = wd;
    mem_lat = lat;
    mem_data = md;
    i_tbl_gnt = gnt;
    for (int c = 1; c <= 30 && got_cyc < 0; c++) begin
      cycle();
      set_n += int'(o_tbl_set_res);
      wr_n += int'(o_tbl_wr_en);
      chk_n += int'(o_tbl_check_res);
      if ((o_tbl_set_res || o_tbl_wr_en) && !i_mem_ack) bad++;
      if (o_tbl_check_res && (o_tbl_id != h[0] || o_tbl_addr != a)) bad++;
      if (o_mem_req) begin
        mem_n++;
        if (o_mem_addr != a || o_mem_we != op[0] || (op[0] && o_mem_wdata != wd)) bad++;
      end
      if (o_ack != '0) begin
        got_cyc = c;
        ackv = o_ack;
        rd = o_rdata;
      end
    end
    i_req[h] = 1'b0;
    cycle();
    check({tag, "_cycles"}, got_cyc, exp_cyc);
    check({tag, "_ackvec"}, 32'(ackv), 32'(1 << h));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_set_res"}, set_n, 32'(op == 2'b10));
    check({tag, "_wr_en"}, wr_n, 32'(op == 2'b01 || (op == 2'b11 && gnt)));
    check({tag, "_check_res"}, chk_n, 32'(op == 2'b11));
    check({tag, "_mem_used"}, 32'(mem_n > 0), 32'(!(op == 2'b11 && !gnt)));
    check({tag, "_fields"}, bad, 0);
    check({tag, "_ack_drop"}, 32'(o_ack), 0);
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] exp);
    int w = 0;
    while (o_ack == '0 && w < 20) begin
      cycle();
      w++;
    end
    check(tag, 32'(o_ack), 32'(exp));
  endtask

  initial begin
    logic [1:0] acc;
    i_rst = 1'b1; i_req = '0; i_op = '0; i_addr = '0; i_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_tbl_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", 32'(o_ack), 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_mem", {o_mem_addr[29:0], o_mem_req, o_mem_we}, 0);
    check("rst_tbl", {o_tbl_addr[27:0], o_tbl_wr_en, o_tbl_set_res, o_tbl_check_res, o_tbl_id}, 0);
    i_rst = 1'b0;
    do_op("load", 0, 2'b00, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 5);
    do_op("lr_a", 0, 2'b10, 32'h200, 32'h0, 2, 32'h77, 1'b0, 32'h77, 4);
    do_op("sc_ok", 0, 2'b11, 32'h200, 32'h5, 1, 32'hFFFF, 1'b1, 32'h0, 4);
    do_op("lr_b", 0, 2'b10, 32'h200, 32'h0, 1, 32'h5, 1'b0, 32'h5, 3);
    do_op("store", 1, 2'b01, 32'h200, 32'h9, 2, 32'hABCD, 1'b0, 32'h0, 4);
    do_op("sc_fail", 0, 2'b11, 32'h200, 32'h6, 1, 32'h0, 1'b0, 32'h1, 2);
    // fresh reset so rr_ptr starts at 0 for the fairness run
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0;
    i_op = '0;
    i_addr = {32'h20, 32'h10};
    mem_lat = 1;
    i_req = 2'b11;
    for (int n = 0; n < 8; n++) begin
      wait_ack($sformatf("arb%0d", n), (n % 2) ? 2'b10 : 2'b01);
      cycle();
    end
    i_req = '0;
    cycle();
    i_addr[31:0] = 32'h300;
    mem_lat = 1000;
    i_req = 2'b01;
    cycle();
    check("rst_pre_req", 32'(o_mem_req), 1);
    i_rst = 1'b1;
    #1;
    check("rst_mid_mem", {o_mem_addr[30:0], o_mem_req}, 0);
    check("rst_mid_tbl", {o_tbl_addr[27:0], o_tbl_wr_en, o_tbl_set_res, o_tbl_check_res, o_tbl_id}, 0);
    check("rst_mid_ack", {o_rdata[29:0], o_ack}, 0);
    i_req = '0;
    cycle();
    i_rst = 1'b0;
    cycle();
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hBAD;
    acc = '0;
    repeat (3) begin
      cycle();
      acc = acc | o_ack | {1'b0, o_mem_req};
    end
    check("rst_late_ack", 32'(acc), 0);
    i_addr = {32'h40, 32'h30};
    mem_lat = 1;
    mem_data = 32'h1234;
    i_req = 2'b11;
    wait_ack("rst_regrant", 2'b01);
    check("rst_regrant_rdata", o_rdata, 32'h1234);
    i_req = '0;
    cycle();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/amo_mem_arbiter.md
Name: amo_mem_arbiter

Overview:
- Shares one data-memory port and one LR/SC reservation table among N_IDS hart requesters.
- Selects one request at a time using round-robin arbitration.
- Sequences each granted operation (load, store, LR, SC) through the memory port and the reservation-table control pins.
- Returns one response per grant.
- Sits between the per-hart data-bus masters and the shared memory / reservation table.

Parameters:
- ADDR_WIDTH, `XLEN: address width.
- DATA_WIDTH, `XLEN: data width.
- N_IDS, 2: number of requesters. Legal range 1..16.
- ID_W, (N_IDS>1 ? $clog2(N_IDS) : 1): id field width. Derived; never overridden.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Asynchronous, active-high.
- i_req  in  N_IDS  per-hart request. Held high until the matching o_ack.
- i_op  in  2*N_IDS  per-hart op, slice [2k+1:2k]: 00 load, 01 store, 10 LR, 11 SC.
- i_addr  in  ADDR_WIDTH*N_IDS  per-hart address.
- i_wdata  in  DATA_WIDTH*N_IDS  per-hart store data.
- o_ack  out  N_IDS  one-cycle completion pulse to the granted hart.
- o_rdata  out  DATA_WIDTH  response data. Valid only while any o_ack bit is high.
- o_mem_req  out  1  memory request. Held until i_mem_ack.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- i_mem_ack  in  1  memory completion. Any latency ≥1 cycle after o_mem_req rises.
- i_mem_rdata  in  DATA_WIDTH  read data. Valid with i_mem_ack.
- o_tbl_wr_en  out  1  pulse: a store to o_tbl_addr committed; the table clears matching reservations.
- o_tbl_set_res  out  1  pulse: set reservation for o_tbl_id at o_tbl_addr.
- o_tbl_check_res  out  1  query reservation for o_tbl_id at o_tbl_addr.
- o_tbl_id  out  ID_W  granted hart id.
- o_tbl_addr  out  ADDR_WIDTH  latched granted address.
- i_tbl_gnt  in  1  reservation valid. Combinational response to check_res.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, rr_ptr=0.
  - Latched id/op/addr/wdata cleared.
  - All outputs 0: o_ack, o_rdata, o_mem_*, o_tbl_* (including o_tbl_addr and o_tbl_id).
  - A memory transaction in flight is abandoned; an i_mem_ack arriving after reset deassertion while in IDLE is ignored.
- FSM states: IDLE, CHECK, MEM, RESP.
- IDLE:
  - If any i_req bit is set, pick the first set bit scanning upward from rr_ptr with wrap.
  - Latch id, op, addr, wdata; set rr_ptr = (id+1) mod N_IDS.
  - Next state: op==SC → CHECK, otherwise → MEM.
  - No request → stay in IDLE; rr_ptr unchanged.
- CHECK, exactly 1 cycle:
  - o_tbl_check_res=1 with o_tbl_id and o_tbl_addr driven; sample i_tbl_gnt.
  - gnt=1 → MEM (write).
  - gnt=0 → RESP with result 1, no memory access.
- MEM:
  - o_mem_req=1; o_mem_we=1 for store or SC, 0 for load or LR; addr/wdata from the latch.
  - On i_mem_ack, o_mem_req drops in the next cycle; next state RESP.
  - Load/LR: capture i_mem_rdata.
  - LR: pulse o_tbl_set_res in the ack cycle.
  - Store/SC: pulse o_tbl_wr_en in the ack cycle. This clears all harts' matching reservations, including the SC issuer's own.
- RESP, 1 cycle:
  - o_ack[id]=1.
  - o_rdata: load/LR → memory data; SC success → 0; SC fail → 1; store → 0.
  - Next state IDLE. A new arbitration can start in the following cycle; a hart's request must drop the cycle after its ack or it is re-granted.
- Latencies, with memory ack M cycles after o_mem_req rises:
  - load/store/LR: o_ack at 2+M cycles after the grant cycle.
  - SC success: 3+M.
  - SC fail: 2.
- o_tbl_* outputs are 0 outside the cycles listed above; o_tbl_addr and o_tbl_id hold the latched values.
- Only one operation is in flight, so the table never sees simultaneous set and wr_en from this block.
- N_IDS=1: arbitration is trivial and rr_ptr stays 0.
- Request bits changing while a hart is not granted are ignored until the next IDLE scan.

Test Plan:
- Hart0 load at 0x100, memory ack after 3 cycles with 0xDEADBEEF → o_mem_we=0, o_ack[0] 5 cycles after grant, o_rdata=0xDEADBEEF, no tbl pulses.
- Hart0 and hart1 both request continuously with rr_ptr=0 → grants alternate 0,1,0,1; neither hart is starved over 8 operations.
- Hart0 LR at 0x200, then hart0 SC at 0x200 with wdata 5, table returns gnt=1 → set_res pulse on the LR ack; for the SC, check_res then a memory write of 5, wr_en pulse, o_rdata=0.
- Hart0 LR at 0x200, hart1 store at 0x200 (wr_en pulse), hart0 SC at 0x200 with table returning gnt=0 → no o_mem_req during the SC; o_ack[0] 2 cycles after grant with o_rdata=1.
- Assert i_rst while in MEM with o_mem_req high → all outputs 0 immediately; a late i_mem_ack produces no o_ack; the next request is granted normally with rr_ptr=0.
